// File: rtl/baud_gen_os.sv
// Fractional-N baud-rate generator: oversample tick, bit tick and square-wave baud output,
// with eight selectable rates and glitch-free rate changes applied at bit boundaries.
`timescale 1ns/1ps

module baud_gen_os #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FRAC_BITS  = 4
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic                          en,
    input  logic [2:0]                    baud_sel,
    input  logic [DIV_W+FRAC_BITS-1:0]    custom_div,
    input  logic                          sync,
    output logic                          tick_os,
    output logic                          tick_baud,
    output logic                          baud_out,
    output logic [2:0]                    active_sel,
    output logic                          update_pend
);

    localparam int unsigned DW    = DIV_W + FRAC_BITS;
    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam int unsigned CNT_W = DIV_W + 1;

    // Rounded Q(DIV_W.FRAC_BITS) clocks per oversample tick for a given baud rate.
    function automatic logic [DW-1:0] table_div(input longint unsigned baud);
        longint unsigned num;
        longint unsigned den;
        num = longint'(CLK_FREQ) << FRAC_BITS;
        den = baud * longint'(OVERSAMPLE);
        return DW'(((num << 1) + den) / (den << 1));
    endfunction

    function automatic logic [DW-1:0] clamp_div(input logic [DW-1:0] d);
        if (d[DW-1:FRAC_BITS] < DIV_W'(2))
            return {DIV_W'(2), {FRAC_BITS{1'b0}}};
        return d;
    endfunction

    localparam logic [DW-1:0] DIV_2400   = table_div(2400);
    localparam logic [DW-1:0] DIV_4800   = table_div(4800);
    localparam logic [DW-1:0] DIV_9600   = table_div(9600);
    localparam logic [DW-1:0] DIV_19200  = table_div(19200);
    localparam logic [DW-1:0] DIV_38400  = table_div(38400);
    localparam logic [DW-1:0] DIV_57600  = table_div(57600);
    localparam logic [DW-1:0] DIV_115200 = table_div(115200);
    localparam logic [DW-1:0] RESET_DIV  = clamp_div(DIV_2400);

    logic [DW-1:0]        raw_div;
    logic [DW-1:0]        req_div;
    logic [DW-1:0]        active_div;
    logic [DIV_W-1:0]     div_int;
    logic [FRAC_BITS-1:0] div_frac;
    logic [FRAC_BITS-1:0] acc;
    logic [FRAC_BITS:0]   acc_sum;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     period_len;
    logic [OS_W-1:0]      os_cnt;
    logic [OS_W-1:0]      os_next;
    logic                 period_end;
    logic                 bit_end;
    logic                 req_differs;

    always_comb begin
        raw_div = custom_div;
        case (baud_sel)
            3'd0:    raw_div = DIV_2400;
            3'd1:    raw_div = DIV_4800;
            3'd2:    raw_div = DIV_9600;
            3'd3:    raw_div = DIV_19200;
            3'd4:    raw_div = DIV_38400;
            3'd5:    raw_div = DIV_57600;
            3'd6:    raw_div = DIV_115200;
            default: raw_div = custom_div;
        endcase
        req_div     = clamp_div(raw_div);
        req_differs = (req_div != active_div);
    end

    // acc holds the phase before the current period; its carry lengthens that period by one.
    always_comb begin
        div_int    = active_div[DW-1:FRAC_BITS];
        div_frac   = active_div[FRAC_BITS-1:0];
        acc_sum    = {1'b0, acc} + {1'b0, div_frac};
        period_len = {1'b0, div_int} + CNT_W'(acc_sum[FRAC_BITS]);
        period_end = (cnt == period_len - CNT_W'(1));
        bit_end    = period_end && (os_cnt == OS_W'(OVERSAMPLE - 1));
        os_next    = bit_end ? '0 : os_cnt + OS_W'(1);
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            acc         <= '0;
            os_cnt      <= '0;
            tick_os     <= 1'b0;
            tick_baud   <= 1'b0;
            baud_out    <= 1'b0;
            active_div  <= RESET_DIV;
            active_sel  <= '0;
            update_pend <= 1'b0;
        end else begin
            update_pend <= req_differs;
            if (!en || sync) begin
                cnt        <= '0;
                acc        <= '0;
                os_cnt     <= '0;
                tick_os    <= 1'b0;
                tick_baud  <= 1'b0;
                baud_out   <= 1'b0;
                active_div <= req_div;
                active_sel <= baud_sel;
            end else begin
                tick_os   <= period_end;
                tick_baud <= bit_end;
                if (period_end) begin
                    cnt      <= '0;
                    os_cnt   <= os_next;
                    baud_out <= (os_next >= OS_W'(OVERSAMPLE / 2));
                    // New divisor takes over at the period that starts with tick_baud.
                    if (bit_end && req_differs) begin
                        active_div <= req_div;
                        active_sel <= baud_sel;
                        acc        <= '0;
                    end else begin
                        acc <= acc_sum[FRAC_BITS-1:0];
                    end
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
